rf_wb_arbiter: RTL

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter_pkg.sv | 19 +
 rtl/rr_select.sv | 32 +++
 rtl/rf_wb_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Holds the FSM state encoding, register-file geometry and the stall-counter helper.
package rf_wb_arbiter_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_NREGS  = 32;
  localparam int STALL_W   = 16;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (v == {STALL_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin selector: one-hot grant to the first valid requester at or after ptr,
// scanning upward with wrap; all-zero when nothing is valid.
module rr_select
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt
);

  int   base;
  logic found;

  // Offset i is the scan distance from ptr; the first offset hitting a valid bit wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    base  = int'(ptr);
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && valid[j] && (j == (base + i) % NREQ)) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: zero-fills x1..x31 after reset, then grants one
// requester per cycle round-robin and presents the chosen write on registered RF ports.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int INIT_CLEAR = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [RF_ADDR_W*NREQ-1:0] req_rd,
  input  logic [RF_DATA_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic [RF_ADDR_W-1:0]      RFrd,
  output logic [RF_DATA_W-1:0]      RFwr,
  output logic                      RFwenable,
  output logic                      init_done,
  output logic [STALL_W-1:0]        stall_cnt
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: requester i transfers in any cycle where req_valid[i] & req_ready[i].
  state_e                 state_q, state_d;
  logic [RF_ADDR_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [RF_ADDR_W-1:0]   rfrd_q, rfrd_d;
  logic [RF_DATA_W-1:0]   rfwr_q, rfwr_d;
  logic                   rfwen_q, rfwen_d;
  logic                   init_done_q, init_done_d;
  logic [STALL_W-1:0]     stall_q, stall_d;

  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        hs;
  logic [RF_ADDR_W-1:0]   sel_rd;
  logic [RF_DATA_W-1:0]   sel_data;
  logic [PTR_W-1:0]       sel_ptr;

  rr_select #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_select (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .gnt   (gnt)
  );

  // Grants are suppressed during the fill and while reset is held.
  assign req_ready = (rst_n && state_q == RUN) ? gnt : '0;
  assign hs        = req_valid & req_ready;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    sel_ptr  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) begin
        sel_rd   = req_rd[RF_ADDR_W*i +: RF_ADDR_W];
        sel_data = req_data[RF_DATA_W*i +: RF_DATA_W];
        sel_ptr  = PTR_W'((i + 1) % NREQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    rfrd_d      = rfrd_q;
    rfwr_d      = rfwr_q;
    rfwen_d     = 1'b0;
    init_done_d = init_done_q;
    stall_d     = (|(req_valid & ~req_ready)) ? sat_inc(stall_q) : stall_q;
    case (state_q)
      INIT: begin
        rfrd_d  = cnt_q;
        rfwr_d  = '0;
        rfwen_d = 1'b1;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'(RF_NREGS - 1)) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        if (|hs) begin
          rfrd_d   = sel_rd;
          rfwr_d   = sel_data;
          rfwen_d  = (sel_rd != '0);
          rr_ptr_d = sel_ptr;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= (INIT_CLEAR != 0) ? INIT : RUN;
      cnt_q       <= 5'd1;
      rr_ptr_q    <= '0;
      rfrd_q      <= '0;
      rfwr_q      <= '0;
      rfwen_q     <= 1'b0;
      init_done_q <= (INIT_CLEAR != 0) ? 1'b0 : 1'b1;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rfrd_q      <= rfrd_d;
      rfwr_q      <= rfwr_d;
      rfwen_q     <= rfwen_d;
      init_done_q <= init_done_d;
      stall_q     <= stall_d;
    end
  end

  assign RFrd      = rfrd_q;
  assign RFwr      = rfwr_q;
  assign RFwenable = rfwen_q;
  assign init_done = init_done_q;
  assign stall_cnt = stall_q;

endmodule
